sig_accum_chk: RTL and testbench
================================

# sig_accum_chk

Downstream signature compactor for the select-flop regression benches: it consumes the per-cycle result vector produced by the unit under test and folds it into a MISR signature. Framing is warm-up / accumulate / compare. After a fixed number of accepted samples it compares the signature against an expected constant and reports a single pass/fail verdict. The block replaces the hand-written sum/cycle-window logic in bench top levels with one reusable, self-checking stage.

## Interface
- WIDTH, 64, sample and signature width; must be >= 4
- WARMUP, 9, number of accepted samples discarded before accumulation; 0 is legal
- WINDOW, 80, number of accepted samples folded into the signature; must be >= 1
- EXPECTED, 64'h0, golden signature compared at window end (WIDTH bits)
- TIMEOUT, 16, max idle cycles without in_valid while busy; used only with SIG_ACCUM_TIMEOUT_EN
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  begin a run; sampled only in IDLE
- in_valid  input  1  in_data is a sample this cycle
- in_data  input  WIDTH  result vector from the unit under test
- busy  output  1  high in WARMUP and ACCUM
- done  output  1  one-cycle pulse when a run ends (normal end or timeout)
- pass  output  1  verdict of the last completed run; held until the next start
- timeout  output  1  last run ended by timeout; held until the next start
- signature  output  WIDTH  current MISR register contents

## Operation
- States: IDLE, WARMUP, ACCUM.
- IDLE + start=1:
  - clear signature, pass, timeout and the sample counter.
  - go to WARMUP, or directly to ACCUM if WARMUP=0.
- start is ignored in WARMUP and ACCUM.
- WARMUP:
  - each in_valid increments the counter; signature stays 0.
  - when the count reaches WARMUP: reset the counter and enter ACCUM.
- ACCUM: each in_valid updates the signature as sig <= in_data ^ {sig[WIDTH-2:0], sig[WIDTH-1]^sig[2]^sig[0]}.
- On the WINDOW-th accepted ACCUM sample:
  - the signature update still happens.
  - next cycle: state=IDLE, done=1, pass=(updated signature == EXPECTED).
- in_valid=0 cycles change nothing except the idle counter.
- in_valid in IDLE is ignored.
- Counters are sized for max(WARMUP, WINDOW, TIMEOUT) with no wrap. A count equal to the limit always terminates the phase.
- The signature is held after done until the next start, so it can be read out.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, done=0, pass=0, timeout=0, signature=0, all counters 0.
- start in IDLE at edge N: busy=1 from N+1. A sample presented in the same cycle as start is not accepted.
- Sample acceptance is same-edge: signature reflects a sample one cycle after the edge it was presented at.
- Last sample at edge N: done=1, pass valid and busy=0 during cycle N+1. done is low at N+2.
- start asserted in the done cycle (state already IDLE) is accepted.
- Reset mid-run aborts immediately. No done pulse is produced, and pass and timeout read 0.

## Configuration
- SIG_ACCUM_TIMEOUT_EN defined:
  - an idle counter clears on every in_valid and on start, and increments on each busy cycle with in_valid=0.
  - when it reaches TIMEOUT, the next cycle gives state=IDLE, done=1, pass=0, timeout=1; the signature is frozen.
  - if in_valid arrives on the same cycle the count would reach TIMEOUT, the sample wins and no timeout occurs.
- SIG_ACCUM_TIMEOUT_EN undefined: no idle counter; timeout is tied 0; a run waits indefinitely for samples.

## Test plan
- Reset values: hold rst_n=0 with start=1 and in_valid=1 -> busy=0, done=0, pass=0, timeout=0, signature=0.
- Signature arithmetic:
  - setup: WIDTH=8, WARMUP=2, WINDOW=3, EXPECTED=8'h87; start, then samples 8'hFF, 8'hFF (discarded), 8'h01, 8'h00, 8'h80 on consecutive cycles.
  - required: signature goes 01, 03, 87; done pulses one cycle after the 8'h80 sample with pass=1.
  - repeat with EXPECTED=8'h86 -> pass=0.
- Gapped input: same stream with in_valid low for 3 cycles between each sample -> same signature 8'h87. done arrives one cycle after the last sample.
- Start handling:
  - start pulsed during ACCUM -> no effect, final signature 8'h87.
  - start in the done cycle -> new run begins and pass/signature clear next cycle.
- Reset mid-run: drop rst_n after 2 ACCUM samples -> immediate IDLE, signature=0, no done pulse.
- Timeout (SIG_ACCUM_TIMEOUT_EN, TIMEOUT=4):
  - start, then no in_valid -> done=1, timeout=1, pass=0 on the cycle after the 4th idle busy cycle.
  - sample arriving exactly on the 4th idle cycle -> no timeout.
  - without the macro, the same stimulus leaves busy=1 indefinitely and timeout=0.

Source files
------------

// File: rtl/sig_accum_chk.sv
// sig_accum_chk: signature compactor for regression benches.
//
// A run is started with start (sampled only while idle). The first WARMUP
// accepted samples are discarded. The next WINDOW accepted samples are folded
// into a MISR signature. After the last sample, done pulses for one cycle and
// pass reports whether the signature matched EXPECTED.
//
// Optional feature, controlled by the macro SIG_ACCUM_TIMEOUT_EN:
//   defined   - a run that sees TIMEOUT consecutive busy cycles without
//               in_valid ends with done=1, pass=0 and timeout=1.
//   undefined - there is no idle counter, timeout is tied 0, and a run waits
//               for samples indefinitely.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      begin a run (ignored unless idle)
//   in_valid   in_data holds a sample this cycle
//   in_data    sample vector [WIDTH-1:0]
//   busy       run in progress (warm-up or accumulate)
//   done       one-cycle pulse at the end of a run
//   pass       verdict of the last completed run, held until next start
//   timeout    last run ended by timeout, held until next start
//   signature  current MISR contents [WIDTH-1:0]
module sig_accum_chk #(
    parameter int                 WIDTH    = 64,
    parameter int                 WARMUP   = 9,
    parameter int                 WINDOW   = 80,
    parameter logic [WIDTH-1:0]   EXPECTED = '0,
    parameter int                 TIMEOUT  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [WIDTH-1:0] signature
);

    // One counter width covers every phase limit, so no count can wrap.
    localparam int MAX_AB = (WARMUP > WINDOW) ? WARMUP : WINDOW;
    localparam int MAX_C  = (MAX_AB > TIMEOUT) ? MAX_AB : TIMEOUT;
    localparam int CNT_W  = (MAX_C < 1) ? 1 : $clog2(MAX_C + 1);

    localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'((WARMUP > 0) ? WARMUP - 1 : 0);
    localparam logic [CNT_W-1:0] WIN_LAST  = CNT_W'((WINDOW > 0) ? WINDOW - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WARMUP,
        S_ACCUM
    } state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [WIDTH-1:0]   sig, sig_nx, sig_step;
    logic               done_r, done_nx;
    logic               pass_r, pass_nx;
    logic               to_r, to_nx;

`ifdef SIG_ACCUM_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    logic [CNT_W-1:0]   idle_cnt, idle_nx;
`endif

    // MISR step: shift left, feedback taps at bits WIDTH-1, 2 and 0.
    assign sig_step = in_data ^ {sig[WIDTH-2:0], sig[WIDTH-1] ^ sig[2] ^ sig[0]};

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        sig_nx   = sig;
        done_nx  = 1'b0;
        pass_nx  = pass_r;
        to_nx    = to_r;
`ifdef SIG_ACCUM_TIMEOUT_EN
        idle_nx  = idle_cnt;
`endif
        case (state)
            S_IDLE: begin
                if (start) begin
                    sig_nx   = '0;
                    pass_nx  = 1'b0;
                    to_nx    = 1'b0;
                    cnt_nx   = '0;
                    state_nx = (WARMUP == 0) ? S_ACCUM : S_WARMUP;
                end
            end
            S_WARMUP: begin
                if (in_valid) begin
                    if (cnt == WARM_LAST) begin
                        cnt_nx   = '0;
                        state_nx = S_ACCUM;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
            end
            S_ACCUM: begin
                if (in_valid) begin
                    sig_nx = sig_step;
                    if (cnt == WIN_LAST) begin
                        cnt_nx   = '0;
                        state_nx = S_IDLE;
                        done_nx  = 1'b1;
                        pass_nx  = (sig_step == EXPECTED);
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase

`ifdef SIG_ACCUM_TIMEOUT_EN
        // A sample on the cycle the idle count would expire wins: in_valid
        // is tested first, so the timeout branch is never reached.
        if (state != S_IDLE) begin
            if (in_valid) begin
                idle_nx = '0;
            end else if (idle_cnt == TO_LAST) begin
                idle_nx  = '0;
                state_nx = S_IDLE;
                done_nx  = 1'b1;
                pass_nx  = 1'b0;
                to_nx    = 1'b1;
                cnt_nx   = '0;
            end else begin
                idle_nx = idle_cnt + 1'b1;
            end
        end else if (start) begin
            idle_nx = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            sig    <= '0;
            done_r <= 1'b0;
            pass_r <= 1'b0;
            to_r   <= 1'b0;
`ifdef SIG_ACCUM_TIMEOUT_EN
            idle_cnt <= '0;
`endif
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            sig    <= sig_nx;
            done_r <= done_nx;
            pass_r <= pass_nx;
            to_r   <= to_nx;
`ifdef SIG_ACCUM_TIMEOUT_EN
            idle_cnt <= idle_nx;
`endif
        end
    end

    assign busy      = (state != S_IDLE);
    assign done      = done_r;
    assign pass      = pass_r;
    assign signature = sig;
`ifdef SIG_ACCUM_TIMEOUT_EN
    assign timeout   = to_r;
`else
    // to_r never leaves 0 without the idle counter; the port is tied low.
    logic unused_to;
    assign unused_to = to_r;
    assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_sig_accum_chk.sv
// Testbench for sig_accum_chk (WIDTH=8, WARMUP=2, WINDOW=3, TIMEOUT=4).
// Two instances share all inputs: dut_a expects 8'h87, dut_b expects 8'h86.
module tb_sig_accum_chk;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;

    logic       busy_a, done_a, pass_a, to_a;
    logic [7:0] sig_a;
    logic       busy_b, done_b, pass_b, to_b;
    logic [7:0] sig_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sig_accum_chk #(.WIDTH(8), .WARMUP(2), .WINDOW(3), .EXPECTED(8'h87), .TIMEOUT(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .busy(busy_a), .done(done_a), .pass(pass_a), .timeout(to_a), .signature(sig_a)
    );

    sig_accum_chk #(.WIDTH(8), .WARMUP(2), .WINDOW(3), .EXPECTED(8'h86), .TIMEOUT(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .busy(busy_b), .done(done_b), .pass(pass_b), .timeout(to_b), .signature(sig_b)
    );

    typedef struct {
        logic       s;
        logic       v;
        logic [7:0] d;
        logic       busy;
        logic       done;
        logic       pa;
        logic       pb;
        logic [7:0] sig;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic s, logic v, logic [7:0] d, logic b, logic dn,
                                logic pa, logic pb, logic [7:0] sg);
        vec_t r;
        r.s = s; r.v = v; r.d = d; r.busy = b; r.done = dn; r.pa = pa; r.pb = pb; r.sig = sg;
        return r;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply inputs, let one rising edge pass, sample 1 time unit later.
    task automatic step(input logic s, input logic v, input logic [7:0] d);
        start = s; in_valid = v; in_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ctl(input string tag, input logic b, input logic dn, input logic to);
        chk({tag, ".busy_a"}, {7'd0, busy_a}, {7'd0, b});
        chk({tag, ".busy_b"}, {7'd0, busy_b}, {7'd0, b});
        chk({tag, ".done_a"}, {7'd0, done_a}, {7'd0, dn});
        chk({tag, ".done_b"}, {7'd0, done_b}, {7'd0, dn});
        chk({tag, ".to_a"},   {7'd0, to_a},   {7'd0, to});
    endtask

    task automatic do_reset();
        start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] gd[5];
        logic [7:0] gs[5];
        logic       to_exp;

        // Reset with start and in_valid held high.
        rst_n = 1'b0; start = 1'b1; in_valid = 1'b1; in_data = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        chk_ctl("reset", 1'b0, 1'b0, 1'b0);
        chk("reset.pass_a", {7'd0, pass_a}, 8'h00);
        chk("reset.sig_a", sig_a, 8'h00);
        chk("reset.sig_b", sig_b, 8'h00);
        start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        rst_n = 1'b1;
        step(1'b0, 1'b0, 8'h00);

        // Run 1: basic arithmetic; idle-state sample ignored.
        tbl.push_back(mk(1, 0, 8'h00, 1, 0, 0, 0, 8'h00));
        tbl.push_back(mk(0, 1, 8'hFF, 1, 0, 0, 0, 8'h00));
        tbl.push_back(mk(0, 1, 8'hFF, 1, 0, 0, 0, 8'h00));
        tbl.push_back(mk(0, 1, 8'h01, 1, 0, 0, 0, 8'h01));
        tbl.push_back(mk(0, 1, 8'h00, 1, 0, 0, 0, 8'h03));
        tbl.push_back(mk(0, 1, 8'h80, 0, 1, 1, 0, 8'h87));
        tbl.push_back(mk(0, 1, 8'h55, 0, 0, 1, 0, 8'h87));
        // Run 2: sample in the start cycle is not accepted.
        tbl.push_back(mk(1, 1, 8'hAA, 1, 0, 0, 0, 8'h00));
        tbl.push_back(mk(0, 1, 8'hFF, 1, 0, 0, 0, 8'h00));
        tbl.push_back(mk(0, 1, 8'hFF, 1, 0, 0, 0, 8'h00));
        tbl.push_back(mk(0, 1, 8'h01, 1, 0, 0, 0, 8'h01));
        tbl.push_back(mk(0, 1, 8'h00, 1, 0, 0, 0, 8'h03));
        tbl.push_back(mk(0, 1, 8'h80, 0, 1, 1, 0, 8'h87));
        // Run 3: start in the done cycle, start ignored during ACCUM.
        tbl.push_back(mk(1, 0, 8'h00, 1, 0, 0, 0, 8'h00));
        tbl.push_back(mk(0, 1, 8'hFF, 1, 0, 0, 0, 8'h00));
        tbl.push_back(mk(0, 1, 8'hFF, 1, 0, 0, 0, 8'h00));
        tbl.push_back(mk(0, 1, 8'h01, 1, 0, 0, 0, 8'h01));
        tbl.push_back(mk(1, 0, 8'h00, 1, 0, 0, 0, 8'h01));
        tbl.push_back(mk(1, 1, 8'h00, 1, 0, 0, 0, 8'h03));
        tbl.push_back(mk(0, 1, 8'h80, 0, 1, 1, 0, 8'h87));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 0, 8'h87));

        for (int i = 0; i < tbl.size(); i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            step(tbl[i].s, tbl[i].v, tbl[i].d);
            chk_ctl(tag, tbl[i].busy, tbl[i].done, 1'b0);
            chk({tag, ".pass_a"}, {7'd0, pass_a}, {7'd0, tbl[i].pa});
            chk({tag, ".pass_b"}, {7'd0, pass_b}, {7'd0, tbl[i].pb});
            chk({tag, ".sig_a"}, sig_a, tbl[i].sig);
            chk({tag, ".sig_b"}, sig_b, tbl[i].sig);
        end

        // Gapped input: three idle cycles between samples.
        gd = '{8'hFF, 8'hFF, 8'h01, 8'h00, 8'h80};
        gs = '{8'h00, 8'h00, 8'h01, 8'h03, 8'h87};
        step(1'b1, 1'b0, 8'h00);
        chk_ctl("gap.start", 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b1, gd[k]);
            chk($sformatf("gap.s%0d.sig", k), sig_a, gs[k]);
            if (k < 4) begin
                chk_ctl($sformatf("gap.s%0d", k), 1'b1, 1'b0, 1'b0);
                for (int g = 0; g < 3; g++) begin
                    step(1'b0, 1'b0, 8'h00);
                    chk_ctl($sformatf("gap.s%0d.g%0d", k, g), 1'b1, 1'b0, 1'b0);
                    chk($sformatf("gap.s%0d.g%0d.sig", k, g), sig_a, gs[k]);
                end
            end else begin
                chk_ctl("gap.last", 1'b0, 1'b1, 1'b0);
                chk("gap.last.pass_a", {7'd0, pass_a}, 8'h01);
                chk("gap.last.pass_b", {7'd0, pass_b}, 8'h00);
            end
        end
        step(1'b0, 1'b0, 8'h00);
        chk_ctl("gap.after", 1'b0, 1'b0, 1'b0);

        // Reset mid-run after two ACCUM samples.
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'hFF);
        step(1'b0, 1'b1, 8'hFF);
        step(1'b0, 1'b1, 8'h01);
        step(1'b0, 1'b1, 8'h00);
        chk("midrst.pre.sig", sig_a, 8'h03);
        in_data = 8'h80;
        #1 rst_n = 1'b0;
        #1;
        chk_ctl("midrst.async", 1'b0, 1'b0, 1'b0);
        chk("midrst.async.sig", sig_a, 8'h00);
        chk("midrst.async.pass", {7'd0, pass_a}, 8'h00);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, 8'h00);
            chk_ctl($sformatf("midrst.after%0d", i), 1'b0, 1'b0, 1'b0);
            chk($sformatf("midrst.after%0d.sig", i), sig_a, 8'h00);
        end

        // Idle run: no samples after start.
        step(1'b1, 1'b0, 8'h00);
        chk_ctl("idle.start", 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 6; i++) begin
            step(1'b0, 1'b0, 8'h00);
`ifdef SIG_ACCUM_TIMEOUT_EN
            if (i < 4)       chk_ctl($sformatf("idle.c%0d", i), 1'b1, 1'b0, 1'b0);
            else if (i == 4) chk_ctl("idle.timeout", 1'b0, 1'b1, 1'b1);
            else             chk_ctl($sformatf("idle.c%0d", i), 1'b0, 1'b0, 1'b1);
            to_exp = (i >= 4);
`else
            chk_ctl($sformatf("idle.c%0d", i), 1'b1, 1'b0, 1'b0);
            to_exp = 1'b0;
`endif
            chk($sformatf("idle.c%0d.to_b", i), {7'd0, to_b}, {7'd0, to_exp});
            chk($sformatf("idle.c%0d.pass", i), {7'd0, pass_a}, 8'h00);
            chk($sformatf("idle.c%0d.sig", i), sig_a, 8'h00);
        end
        do_reset();

        // Sample arriving on the 4th idle cycle prevents a timeout.
        step(1'b1, 1'b0, 8'h00);
        for (int i = 1; i <= 3; i++) begin
            step(1'b0, 1'b0, 8'h00);
            chk_ctl($sformatf("save.c%0d", i), 1'b1, 1'b0, 1'b0);
        end
        step(1'b0, 1'b1, 8'hFF);
        chk_ctl("save.sample", 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            step(1'b0, 1'b0, 8'h00);
            chk_ctl($sformatf("save.post%0d", i), 1'b1, 1'b0, 1'b0);
        end
        do_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
